// File: rtl/mdu_iter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_iter_if
//  Description : Request/result bundle of the iterative multiply/divide unit.
//                The pipeline side (master) issues ops and flushes. The unit
//                side (slave) returns busy/done and the HI/LO registers.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             abort;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, abort,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, abort,
        output busy, done, div_by_zero, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_iter
//  Description : Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
//                Radix-2 shift-add multiply and restoring divide run on
//                unsigned magnitudes for WIDTH cycles. A one-cycle FIX state
//                then applies the sign correction and writes HI/LO.
//                MTHI/MTLO write HI/LO directly in a single cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  wire          clk,
    input  wire          rst,      // asynchronous, active-low
    mdu_iter_if.slave    bus
);

    localparam int                 c_CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [2:0] c_OP_MULT  = 3'b000;
    localparam logic [2:0] c_OP_MULTU = 3'b001;
    localparam logic [2:0] c_OP_DIV   = 3'b010;
    localparam logic [2:0] c_OP_DIVU  = 3'b011;
    localparam logic [2:0] c_OP_MTHI  = 3'b100;
    localparam logic [2:0] c_OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_div_by_zero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    // Working set. For multiply, r_work_hi is the partial-product upper half
    // and r_work_lo holds the multiplier as it shifts out. For divide,
    // r_work_hi is the partial remainder and r_work_lo shifts the dividend out
    // while the quotient bits shift in.
    logic [WIDTH-1:0]   r_work_hi;
    logic [WIDTH-1:0]   r_work_lo;
    logic [WIDTH-1:0]   r_opnd;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   r_a_raw;     // original dividend, returned on divide by zero
    logic               r_is_div;
    logic               r_neg_res;   // operand signs differ: negate product/quotient
    logic               r_neg_rem;   // dividend negative: negate remainder
    logic               r_dbz;       // current op is a divide with b == 0

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic               w_is_md;
    logic               w_is_div;
    logic               w_signed;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_next_hi;
    logic [WIDTH-1:0]   w_next_lo;

    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    // Decode the request and form the unsigned operand magnitudes. The
    // magnitude of the most-negative value is 2^(WIDTH-1), which still fits
    // as an unsigned WIDTH-bit number, so the overflow case needs no special
    // handling.
    always_comb begin
        w_is_md  = (bus.op == c_OP_MULT) || (bus.op == c_OP_MULTU) ||
                   (bus.op == c_OP_DIV)  || (bus.op == c_OP_DIVU);
        w_is_div = (bus.op == c_OP_DIV)  || (bus.op == c_OP_DIVU);
        w_signed = (bus.op == c_OP_MULT) || (bus.op == c_OP_DIV);
        w_neg_a  = w_signed && bus.a[WIDTH-1];
        w_neg_b  = w_signed && bus.b[WIDTH-1];
        w_mag_a  = w_neg_a ? (~bus.a + 1'b1) : bus.a;
        w_mag_b  = w_neg_b ? (~bus.b + 1'b1) : bus.b;
    end

    // One iteration step: add-then-shift for multiply, trial-subtract for divide.
    always_comb begin
        w_sum   = {1'b0, r_work_hi} + {1'b0, r_opnd};
        w_shift = {r_work_hi, r_work_lo[WIDTH-1]};
        w_ge    = (w_shift >= {1'b0, r_opnd});
        // The partial remainder stays below the divisor, so the difference
        // always fits in WIDTH bits when w_ge is set.
        w_diff  = w_shift[WIDTH-1:0] - r_opnd;
        if (r_is_div) begin
            w_next_hi = w_ge ? w_diff : w_shift[WIDTH-1:0];
            w_next_lo = {r_work_lo[WIDTH-2:0], w_ge};
        end else if (r_work_lo[0]) begin
            {w_next_hi, w_next_lo} = {w_sum, r_work_lo[WIDTH-1:1]};
        end else begin
            {w_next_hi, w_next_lo} = {1'b0, r_work_hi, r_work_lo[WIDTH-1:1]};
        end
    end

    // Sign correction applied in FIX. A divide by zero bypasses the
    // correction and returns all ones in LO and the raw dividend in HI.
    always_comb begin
        w_prod     = {r_work_hi, r_work_lo};
        w_prod_fix = r_neg_res ? (~w_prod + 1'b1) : w_prod;
        if (r_is_div) begin
            if (r_dbz) begin
                w_fix_hi = r_a_raw;
                w_fix_lo = '1;
            end else begin
                w_fix_hi = r_neg_rem ? (~r_work_hi + 1'b1) : r_work_hi;
                w_fix_lo = r_neg_res ? (~r_work_lo + 1'b1) : r_work_lo;
            end
        end else begin
            w_fix_hi = w_prod_fix[2*WIDTH-1:WIDTH];
            w_fix_lo = w_prod_fix[WIDTH-1:0];
        end
    end

    // Control FSM, iteration datapath and HI/LO result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_div_by_zero <= 1'b0;
            r_hi          <= '0;
            r_lo          <= '0;
            r_work_hi     <= '0;
            r_work_lo     <= '0;
            r_opnd        <= '0;
            r_a_raw       <= '0;
            r_is_div      <= 1'b0;
            r_neg_res     <= 1'b0;
            r_neg_rem     <= 1'b0;
            r_dbz         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // abort outranks start, and unknown op codes fall through
                    if (bus.start && !bus.abort) begin
                        if (w_is_md) begin
                            r_state   <= S_CALC;
                            r_busy    <= 1'b1;
                            r_cnt     <= '0;
                            r_is_div  <= w_is_div;
                            r_work_hi <= '0;
                            r_work_lo <= w_is_div ? w_mag_a : w_mag_b;
                            r_opnd    <= w_is_div ? w_mag_b : w_mag_a;
                            r_a_raw   <= bus.a;
                            r_neg_res <= w_neg_a ^ w_neg_b;
                            r_neg_rem <= w_neg_a;
                            r_dbz     <= w_is_div && (bus.b == '0);
                        end else if (bus.op == c_OP_MTHI) begin
                            r_hi <= bus.a;
                        end else if (bus.op == c_OP_MTLO) begin
                            r_lo <= bus.a;
                        end
                    end
                end
                S_CALC: begin
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_work_hi <= w_next_hi;
                        r_work_lo <= w_next_lo;
                        r_cnt     <= r_cnt + c_CNT_ONE;
                        if (r_cnt == c_CNT_LAST) begin
                            r_state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    if (!bus.abort) begin
                        r_hi          <= w_fix_hi;
                        r_lo          <= w_fix_lo;
                        r_done        <= 1'b1;
                        r_div_by_zero <= r_is_div && r_dbz;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_div_by_zero;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu_iter
//  Description : Self-checking bench for mdu_iter (WIDTH = 32). It runs
//                directed and random ops against a plain-arithmetic reference
//                model, and also covers abort, reset and MTHI/MTLO behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_iter;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [W-1:0] exp_hi  = '0;
    logic [W-1:0] exp_lo  = '0;
    logic         exp_dbz = 1'b0;

    mdu_iter_if #(.WIDTH(W)) bus ();

    mdu_iter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: full-width arithmetic with truncating signed division
    function automatic void ref_md(input logic [2:0] op, input logic [W-1:0] a, b,
                                   output logic [W-1:0] hi, lo, output logic dbz);
        longint           sa, sb, p, q, r;
        logic [2*W-1:0]   up;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        dbz = 1'b0;
        hi  = '0;
        lo  = '0;
        case (op)
            3'b000: begin p = sa * sb; hi = p[2*W-1:W]; lo = p[W-1:0]; end
            3'b001: begin
                up = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                hi = up[2*W-1:W];
                lo = up[W-1:0];
            end
            3'b010, 3'b011: begin
                if (b == '0) begin
                    dbz = 1'b1; hi = a; lo = '1;
                end else if (op == 3'b010) begin
                    q = sa / sb; r = sa % sb;
                    lo = q[W-1:0]; hi = r[W-1:0];
                end else begin
                    lo = a / b; hi = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Issue a mult/div and check timing, the one-cycle done pulse and the result
    task automatic run_md(input logic [2:0] op, input logic [W-1:0] a, b);
        logic [W-1:0] mh, ml;
        logic         md;
        int           n, both;
        string        t;
        ref_md(op, a, b, mh, ml, md);
        t = $sformatf("op%0d a=%h b=%h", op, a, b);
        @(negedge clk);
        bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0; both = 0;
        while (bus.busy === 1'b1 && n < 4*W) begin
            if (bus.done !== 1'b0) both++;
            n++;
            @(negedge clk);
        end
        chk({t, " busy_cycles"}, 64'(n), 64'(W + 1));
        chk({t, " busy_done_overlap"}, 64'(both), 64'd0);
        chk({t, " done"}, 64'(bus.done), 64'd1);
        chk({t, " hi"}, 64'(bus.hi), 64'(mh));
        chk({t, " lo"}, 64'(bus.lo), 64'(ml));
        chk({t, " dbz"}, 64'(bus.div_by_zero), 64'(md));
        @(negedge clk);
        chk({t, " done_single"}, 64'(bus.done), 64'd0);
        exp_hi = mh; exp_lo = ml; exp_dbz = md;
    endtask

    task automatic run_mt(input logic is_hi, input logic [W-1:0] d);
        @(negedge clk);
        bus.op = is_hi ? 3'b100 : 3'b101; bus.a = d; bus.b = $urandom; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        if (is_hi) exp_hi = d; else exp_lo = d;
        chk("mt busy", 64'(bus.busy), 64'd0);
        chk("mt done", 64'(bus.done), 64'd0);
        chk("mt hi", 64'(bus.hi), 64'(exp_hi));
        chk("mt lo", 64'(bus.lo), 64'(exp_lo));
        chk("mt dbz", 64'(bus.div_by_zero), 64'(exp_dbz));
    endtask

    // Watch for n cycles, counting any done pulses
    task automatic count_done(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.done !== 1'b0) pulses++;
        end
    endtask

    task automatic chk_hold(input string t);
        chk({t, " busy"}, 64'(bus.busy), 64'd0);
        chk({t, " hi"}, 64'(bus.hi), 64'(exp_hi));
        chk({t, " lo"}, 64'(bus.lo), 64'(exp_lo));
        chk({t, " dbz"}, 64'(bus.div_by_zero), 64'(exp_dbz));
    endtask

    initial begin
        int           pulses;
        logic [2:0]   rop;
        logic [W-1:0] ra, rb;

        bus.start = 1'b0; bus.op = 3'b000; bus.a = '0; bus.b = '0; bus.abort = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset hi", 64'(bus.hi), 64'd0);
        chk("reset lo", 64'(bus.lo), 64'd0);
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset done", 64'(bus.done), 64'd0);
        chk("reset dbz", 64'(bus.div_by_zero), 64'd0);
        rst = 1'b1;

        // Directed arithmetic cases
        run_md(3'b000, 32'hFFFF_FFFD, 32'd7);
        run_md(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_md(3'b011, 32'd7, 32'd2);
        run_md(3'b010, 32'hFFFF_FFF9, 32'd2);
        run_md(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        run_md(3'b010, 32'd5, 32'd0);
        run_md(3'b001, 32'd2, 32'd3);
        run_md(3'b011, 32'h1234_5678, 32'd0);
        run_md(3'b000, 32'h8000_0000, 32'h8000_0000);

        run_mt(1'b1, 32'h0000_1111);
        run_mt(1'b0, 32'h0000_2222);

        // Abort in CALC; a second start mid-op must be ignored
        @(negedge clk);
        bus.op = 3'b000; bus.a = $urandom; bus.b = $urandom; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.op = 3'b100; bus.a = 32'h0000_9999; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("restart busy", 64'(bus.busy), 64'd1);
        chk("restart hi", 64'(bus.hi), 64'(exp_hi));
        repeat (4) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_calc busy", 64'(bus.busy), 64'd0);
        count_done(2*W, pulses);
        chk("abort_calc done", 64'(pulses), 64'd0);
        chk_hold("abort_calc");

        // Abort in the FIX cycle suppresses the write
        @(negedge clk);
        bus.op = 3'b010; bus.a = 32'd100; bus.b = 32'd0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (W) @(negedge clk);
        chk("abort_fix busy_before", 64'(bus.busy), 64'd1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_fix done_now", 64'(bus.done), 64'd0);
        count_done(4, pulses);
        chk("abort_fix done", 64'(pulses), 64'd0);
        chk_hold("abort_fix");

        // abort together with start in IDLE: start is dropped
        @(negedge clk);
        bus.op = 3'b100; bus.a = 32'h5555_AAAA; bus.start = 1'b1; bus.abort = 1'b1;
        @(negedge clk);
        bus.op = 3'b000; bus.a = 32'd3;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        chk_hold("abort_start");
        count_done(W + 4, pulses);
        chk("abort_start done", 64'(pulses), 64'd0);

        // Invalid op codes behave as no-ops
        @(negedge clk);
        bus.op = 3'b110; bus.a = 32'hCAFE_0000; bus.start = 1'b1;
        @(negedge clk);
        bus.op = 3'b111;
        @(negedge clk);
        bus.start = 1'b0;
        chk_hold("invalid_op");
        count_done(W + 4, pulses);
        chk("invalid_op done", 64'(pulses), 64'd0);

        // Randomised ops, with divide-by-zero, small divisors and overflow mixed in
        for (int k = 0; k < 24; k++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: rb = W'($urandom_range(1, 15));
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: ra = W'($urandom_range(0, 300)) - 32'd150;
                default: ;
            endcase
            run_md(rop, ra, rb);
        end

        run_mt(1'b1, 32'hDEAD_BEEF);

        // Reset in the middle of a divide
        @(negedge clk);
        bus.op = 3'b010; bus.a = $urandom; bus.b = 32'd3; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midreset hi", 64'(bus.hi), 64'd0);
        chk("midreset lo", 64'(bus.lo), 64'd0);
        chk("midreset busy", 64'(bus.busy), 64'd0);
        chk("midreset done", 64'(bus.done), 64'd0);
        chk("midreset dbz", 64'(bus.div_by_zero), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        exp_hi = '0; exp_lo = '0; exp_dbz = 1'b0;
        count_done(2*W + 4, pulses);
        chk("postreset done", 64'(pulses), 64'd0);
        chk_hold("postreset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
